// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory bus between the instruction-fetch requester (I) and the
//   load/store requester (D). One request is latched at a time, the bus strobe
//   is held until bus_busy drops, and the result is returned with a one-cycle
//   ack. A transaction stalled for TIMEOUT cycles in WAIT is aborted with err.
//
// Configuration macro: MEM_ARBITER_RR_EN
//   defined   -> simultaneous requests alternate (round-robin on last_owner)
//   undefined -> fixed priority, D wins over I
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   i_req/i_addr             fetch request and address (held until i_ack)
//   i_ack/i_rdata            fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata load/store request (held until d_ack)
//   d_ack/d_rdata            load/store completion pulse and load data
//   err                      high with the ack of a timed-out transaction
//   bus_read/bus_write       bus strobes
//   bus_addr/bus_wdata       latched address and store data
//   bus_rdata/bus_busy       bus read data and stall
//   owner/busy               current owner (0=I, 1=D) and non-idle flag

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       we;
  logic       grant_d;
  logic       done;
  logic       timed_out;

`ifdef MEM_ARBITER_RR_EN
  logic last_owner;

  // Under contention hand the bus to whoever did not own it last.
  always_comb begin
    grant_d = d_req;
    if (i_req && d_req)
      grant_d = ~last_owner;
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  // A transaction finishes when the bus stops stalling, or when the stall has
  // lasted TIMEOUT cycles in WAIT.
  always_comb begin
    timed_out = (state == WAIT) && bus_busy && (cnt == CNT_LAST);
    done      = ((state == REQ) || (state == WAIT)) && (!bus_busy || timed_out);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we        <= 1'b0;
      owner     <= 1'b0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner     <= grant_d;
            we        <= grant_d && d_we;
            bus_addr  <= grant_d ? d_addr : i_addr;
            bus_wdata <= (grant_d && d_we) ? d_wdata : '0;
            bus_read  <= !(grant_d && d_we);
            bus_write <= grant_d && d_we;
            state     <= REQ;
          end
        end
        REQ, WAIT: begin
          if (done) begin
            // Strobes drop as the response is presented; stores and
            // timeouts return zero data.
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            i_ack     <= !owner;
            d_ack     <= owner;
            i_rdata   <= (!owner && !timed_out) ? bus_rdata : '0;
            d_rdata   <= (owner && !we && !timed_out) ? bus_rdata : '0;
            err       <= timed_out;
            state     <= RESP;
          end else if (state == REQ) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          i_rdata <= '0;
          d_rdata <= '0;
          err     <= 1'b0;
          state   <= IDLE;
`ifdef MEM_ARBITER_RR_EN
          last_owner <= owner;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed testbench for mem_arbiter (TIMEOUT=4). A table of per-cycle
//   vectors covers reset, fetch, stalled store, timeout and mid-op reset; a
//   hand-written sequence covers sustained contention.

module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_busy;
  logic        owner;
  logic        busy;

  int vectors;
  int miscompares;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic        x_i_ack;
    logic [31:0] x_i_rdata;
    logic        x_d_ack;
    logic [31:0] x_d_rdata;
    logic        x_err;
    logic        x_read;
    logic        x_write;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_owner;
    logic        x_busy;
  } vec_t;

  vec_t tbl[$];

  // Inputs, then outputs expected just after the following rising edge.
  // bus_addr/bus_wdata are only checked while a strobe is expected.
  function automatic vec_t mk(
    input logic rs, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
    input logic [31:0] br, input logic bb,
    input logic xia, input logic [31:0] xir, input logic xda, input logic [31:0] xdr,
    input logic xe, input logic xr, input logic xw, input logic [31:0] xa,
    input logic [31:0] xwd, input logic xo, input logic xb);
    vec_t v;
    v.rst = rs; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.bus_rdata = br; v.bus_busy = bb;
    v.x_i_ack = xia; v.x_i_rdata = xir; v.x_d_ack = xda; v.x_d_rdata = xdr;
    v.x_err = xe; v.x_read = xr; v.x_write = xw; v.x_addr = xa; v.x_wdata = xwd;
    v.x_owner = xo; v.x_busy = xb;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; i_req = v.i_req; i_addr = v.i_addr; d_req = v.d_req; d_we = v.d_we;
    d_addr = v.d_addr; d_wdata = v.d_wdata; bus_rdata = v.bus_rdata; bus_busy = v.bus_busy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic bad;
    bad = (i_ack !== v.x_i_ack) || (i_rdata !== v.x_i_rdata) ||
          (d_ack !== v.x_d_ack) || (d_rdata !== v.x_d_rdata) ||
          (err !== v.x_err) || (bus_read !== v.x_read) || (bus_write !== v.x_write) ||
          (busy !== v.x_busy);
    if (v.x_busy && owner !== v.x_owner) bad = 1'b1;
    if ((v.x_read || v.x_write) && (bus_addr !== v.x_addr || bus_wdata !== v.x_wdata)) bad = 1'b1;
    if (!v.rst && (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || owner !== 1'b0)) bad = 1'b1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL vec%0d got ia=%b ir=%h da=%b dr=%h e=%b r=%b w=%b a=%h wd=%h o=%b b=%b want ia=%b ir=%h da=%b dr=%h e=%b r=%b w=%b a=%h wd=%h o=%b b=%b",
               idx, i_ack, i_rdata, d_ack, d_rdata, err, bus_read, bus_write, bus_addr, bus_wdata, owner, busy,
               v.x_i_ack, v.x_i_rdata, v.x_d_ack, v.x_d_rdata, v.x_err, v.x_read, v.x_write,
               v.x_addr, v.x_wdata, v.x_owner, v.x_busy);
    end
  endtask

  initial begin
    logic        got[$];
    logic [3:0]  want;
    int          cyc;
    vectors     = 0;
    miscompares = 0;

    //          rs ir ia           dr dw da          dd           brd          bb   ia ir           da dr          e  r  w  addr         wdata        o  b
    // reset for two cycles, then idle
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 1, 0, 32'h0,  32'h0,  32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    // fetch, no stall
    tbl.push_back(mk(1, 1, 32'h100, 0, 0, 32'h0,  32'h0,  32'hDEADBEEF, 0,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h100, 32'h0,  0, 1));
    tbl.push_back(mk(1, 1, 32'h100, 0, 0, 32'h0,  32'h0,  32'hDEADBEEF, 0,   1, 32'hDEADBEEF, 0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 1));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    // store, stalled three busy cycles; address change after grant ignored
    tbl.push_back(mk(1, 0, 32'h0,   1, 1, 32'h20, 32'h55, 32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 0, 1, 32'h20,  32'h55, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   1, 1, 32'h99, 32'h77, 32'h0,        1,   0, 32'h0,        0, 32'h0,      0, 0, 1, 32'h20,  32'h55, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   1, 1, 32'h99, 32'h77, 32'h0,        1,   0, 32'h0,        0, 32'h0,      0, 0, 1, 32'h20,  32'h55, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   1, 1, 32'h99, 32'h77, 32'h0,        1,   0, 32'h0,        0, 32'h0,      0, 0, 1, 32'h20,  32'h55, 1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   1, 1, 32'h99, 32'h77, 32'h1234,     0,   0, 32'h0,        1, 32'h0,      0, 0, 0, 32'h0,   32'h0,  1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    // fetch timeout, bus stuck busy
    tbl.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,  32'h0,  32'hAAAA,     0,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h40,  32'h0,  0, 1));
    tbl.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,  32'h0,  32'hAAAA,     1,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h40,  32'h0,  0, 1));
    tbl.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,  32'h0,  32'hAAAA,     1,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h40,  32'h0,  0, 1));
    tbl.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,  32'h0,  32'hAAAA,     1,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h40,  32'h0,  0, 1));
    tbl.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,  32'h0,  32'hAAAA,     1,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h40,  32'h0,  0, 1));
    tbl.push_back(mk(1, 1, 32'h40,  0, 0, 32'h0,  32'h0,  32'hAAAA,     1,   1, 32'h0,        0, 32'h0,      1, 0, 0, 32'h0,   32'h0,  0, 1));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h0,        1,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    // load interrupted by reset while waiting
    tbl.push_back(mk(1, 0, 32'h0,   1, 0, 32'h8,  32'h33, 32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h8,   32'h0,  1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   1, 0, 32'h8,  32'h33, 32'h0,        1,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h8,   32'h0,  1, 1));
    tbl.push_back(mk(0, 0, 32'h0,   1, 0, 32'h8,  32'h33, 32'h0,        1,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h5,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h5,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));
    // load, no stall, returns bus data on d_rdata
    tbl.push_back(mk(1, 0, 32'h0,   1, 0, 32'h44, 32'h0,  32'hCAFE0001, 0,   0, 32'h0,        0, 32'h0,      0, 1, 0, 32'h44,  32'h0,  1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   1, 0, 32'h44, 32'h0,  32'hCAFE0001, 0,   0, 32'h0,        1, 32'hCAFE0001, 0, 0, 0, 32'h0, 32'h0,  1, 1));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  32'h0,        0,   0, 32'h0,        0, 32'h0,      0, 0, 0, 32'h0,   32'h0,  0, 0));

    @(negedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      applyStimulus(tbl[k]);
      checkOutput(k, tbl[k]);
    end

    // Sustained contention: both requests held for four transactions.
`ifdef MEM_ARBITER_RR_EN
    want = 4'b0101;
`else
    want = 4'b1111;
`endif
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    bus_rdata = 32'h0; bus_busy = 1'b0;
    cyc = 0;
    while (got.size() < 4 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (i_ack && d_ack) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dual_ack got i_ack=%b d_ack=%b want only one", i_ack, d_ack);
      end
      if (i_ack || d_ack) got.push_back(d_ack);
    end
    i_req = 1'b0; d_req = 1'b0;
    if (got.size() < 4) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL contention_timeout got %0d acks want 4", got.size());
    end
    for (int t = 0; t < got.size(); t++) begin
      vectors++;
      if (got[t] !== want[3-t]) begin
        miscompares++;
        $display("[TB] FAIL grant%0d got owner=%b want owner=%b", t, got[t], want[3-t]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
